// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master: single-transfer AHB-Lite master fed by a valid/ready command stream.
// Each command becomes one NONSEQ/SINGLE transfer. The address phase of command N+1 overlaps
// the data phase of command N. Exactly one response is returned per command, in command order.
// Ports:
//   HCLK, HRESETn            bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_write/addr/size/wdata carry the command
//   rsp_valid/rdata/error    one-cycle response pulse per command
//   busy                     address or data phase outstanding
//   HADDR..HWDATA            AHB-Lite master outputs (all registered or constant)
//   HREADY, HRESP, HRDATA    AHB-Lite slave-side inputs
module ahbl_cmd_master #(
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Address-phase stage; HADDR/HWRITE/HSIZE double as its address/control fields.
  logic        ap_v;
  logic        ap_cancel;  // AP withdrawn to IDLE by an ERROR response, awaiting reissue
  logic [31:0] ap_wdata;
  // Data-phase stage.
  logic        dp_v;
  logic        dp_write;
  // One-deep slot for a locally rejected (misaligned) command.
  logic        mis_v;

  logic err_first;
  logic ap_done;
  logic dp_done;
  logic cmd_misaligned;
  logic accept_bus;
  logic accept_mis;
  logic mis_fire;

  always_comb begin
    err_first      = HRESP & ~HREADY;
    ap_done        = ap_v & ~ap_cancel & HREADY;
    dp_done        = dp_v & HREADY;
    // A cancelled AP is not on the bus, so HREADY does not free it.
    cmd_ready      = (~ap_v | (HREADY & ~ap_cancel)) & ~err_first & ~mis_v;
    cmd_misaligned = ALIGN_CHECK &&
                     ((cmd_size == 3'd1 && cmd_addr[0]) ||
                      (cmd_size == 3'd2 && cmd_addr[1:0] != 2'b00) ||
                      (cmd_size > 3'd2));
    accept_bus     = cmd_valid & cmd_ready & ~cmd_misaligned;
    accept_mis     = cmd_valid & cmd_ready & cmd_misaligned;
    // Rejected command answers only once everything ahead of it has drained.
    mis_fire       = mis_v & ~ap_v & ~dp_v;
    busy           = ap_v | dp_v;
  end

  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_v      <= 1'b0;
      ap_cancel <= 1'b0;
      ap_wdata  <= '0;
      dp_v      <= 1'b0;
      dp_write  <= 1'b0;
      mis_v     <= 1'b0;
      HADDR     <= '0;
      HTRANS    <= TRANS_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      // Address phase
      if (accept_bus) begin
        ap_v     <= 1'b1;
        HADDR    <= cmd_addr;
        HWRITE   <= cmd_write;
        HSIZE    <= cmd_size;
        ap_wdata <= cmd_wdata;
        HTRANS   <= TRANS_NONSEQ;
      end else if (ap_done) begin
        ap_v   <= 1'b0;
        HTRANS <= TRANS_IDLE;
      end else if (ap_v && err_first) begin
        ap_cancel <= 1'b1;
        HTRANS    <= TRANS_IDLE;
      end else if (ap_cancel && HREADY) begin
        // Second ERROR cycle: put the held command back on the bus.
        ap_cancel <= 1'b0;
        HTRANS    <= TRANS_NONSEQ;
      end

      // Data phase
      if (ap_done) begin
        dp_v     <= 1'b1;
        dp_write <= HWRITE;
        if (HWRITE) begin
          HWDATA <= ap_wdata;
        end
      end else if (dp_done) begin
        dp_v <= 1'b0;
      end

      // Responses; dp_done and mis_fire are mutually exclusive (mis_fire needs !dp_v).
      if (dp_done) begin
        rsp_valid <= 1'b1;
        rsp_error <= HRESP;
        rsp_rdata <= (!dp_write && !HRESP) ? HRDATA : '0;
      end else if (mis_fire) begin
        rsp_valid <= 1'b1;
        rsp_error <= 1'b1;
        rsp_rdata <= '0;
        mis_v     <= 1'b0;
      end

      if (accept_mis) begin
        mis_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_cmd_master.sv
module tb_ahbl_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [31:0] HRDATA = '0;

  always #5 HCLK = ~HCLK;

  ahbl_cmd_master #(
    .HPROT_VAL  (4'b0011),
    .ALIGN_CHECK(1'b1)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_size (cmd_size),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .busy     (busy),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HPROT    (HPROT),
    .HMASTLOCK(HMASTLOCK),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam int N = 1024;

  // Per-command record, indexed in acceptance order.
  logic [31:0] c_addr    [0:N-1];
  logic [31:0] c_wdata   [0:N-1];
  logic [2:0]  c_size    [0:N-1];
  logic        c_write   [0:N-1];
  bit          c_mis     [0:N-1];
  bit          exp_known [0:N-1];
  logic        exp_err   [0:N-1];
  logic [31:0] exp_rdata [0:N-1];
  int          acc_cyc   [0:N-1];
  int          done_cyc  [0:N-1];
  int          rsp_cyc   [0:N-1];
  logic        got_err   [0:N-1];
  logic [31:0] got_rdata [0:N-1];

  int n_acc, n_rsp, n_done, n_aligned_acc;
  int issue_q[$];

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;
  cmd_t send_q[$];

  typedef struct {
    int          waits;
    bit          err;
    bit          fixed;
    logic [31:0] rdata;
  } plan_t;
  plan_t plan_q[$];

  bit rand_slave = 1'b0;
  int gap_pct = 0;

  // Slave model state
  bit          s_dp;
  int          s_idx;
  int          s_waits;
  bit          s_err;
  int          s_err_ph;
  logic [31:0] s_rdata;

  bit          prev_stall;
  bit          prev_errfirst_ap;
  logic [31:0] prev_addr;

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] d);
    cmd_t c;
    c.write = w;
    c.addr  = a;
    c.size  = s;
    c.wdata = d;
    send_q.push_back(c);
  endtask

  task automatic push_plan(input int w, input bit e, input bit f, input logic [31:0] d);
    plan_t p;
    p.waits = w;
    p.err   = e;
    p.fixed = f;
    p.rdata = d;
    plan_q.push_back(p);
  endtask

  task automatic model_reset();
    n_acc = 0;
    n_rsp = 0;
    n_done = 0;
    n_aligned_acc = 0;
    issue_q.delete();
    send_q.delete();
    plan_q.delete();
    s_dp = 1'b0;
    s_waits = 0;
    s_err = 1'b0;
    s_err_ph = 0;
    prev_stall = 1'b0;
    prev_errfirst_ap = 1'b0;
    for (int i = 0; i < N; i++) exp_known[i] = 1'b0;
  endtask

  // One bus cycle: observe outputs, drive slave and command inputs, then commit model state.
  task automatic step();
    plan_t p;
    cmd_t  c;
    int    idx;
    bit    mis;
    @(negedge HCLK);
    cyc++;
    if (rsp_valid) begin
      checks++;
      if (n_rsp >= n_acc) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        rsp_cyc[n_rsp]   = cyc;
        got_err[n_rsp]   = rsp_error;
        got_rdata[n_rsp] = rsp_rdata;
        if (!exp_known[n_rsp] || rsp_error !== exp_err[n_rsp] ||
            rsp_rdata !== exp_rdata[n_rsp]) begin
          errors++;
          $display("FAIL rsp_payload cmd %0d: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   n_rsp, rsp_error, rsp_rdata, exp_err[n_rsp], exp_rdata[n_rsp]);
        end
        if (!c_mis[n_rsp]) begin
          checks++;
          if (cyc != done_cyc[n_rsp] + 1) begin
            errors++;
            $display("FAIL rsp_timing cmd %0d: got cycle %0d, required %0d",
                     n_rsp, cyc, done_cyc[n_rsp] + 1);
          end
        end
        n_rsp++;
      end
    end
    checks++;
    if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0 ||
        !(HTRANS === 2'b00 || HTRANS === 2'b10)) begin
      errors++;
      $display("FAIL bus_const: got HBURST=%b HPROT=%b HMASTLOCK=%b HTRANS=%b, required 000 0011 0 00/10",
               HBURST, HPROT, HMASTLOCK, HTRANS);
    end
    if (prev_stall) begin
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== prev_addr) begin
        errors++;
        $display("FAIL ap_hold: got HTRANS=%b HADDR=%h, required 10 %h", HTRANS, HADDR, prev_addr);
      end
    end
    if (prev_errfirst_ap) begin
      checks++;
      if (HTRANS !== 2'b00) begin
        errors++;
        $display("FAIL err_cancel: got HTRANS=%b, required 00", HTRANS);
      end
    end
    checks++;
    if (busy !== (n_aligned_acc != n_done)) begin
      errors++;
      $display("FAIL busy: got %0b, required %0b", busy, n_aligned_acc != n_done);
    end

    // Slave response for this cycle
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = $urandom;
    if (s_dp) begin
      if (s_waits > 0) begin
        HREADY = 1'b0;
        s_waits--;
      end else if (s_err && s_err_ph == 0) begin
        HREADY = 1'b0;
        HRESP = 1'b1;
        s_err_ph = 1;
      end else if (s_err) begin
        HRESP = 1'b1;
      end else begin
        HRDATA = s_rdata;
      end
    end

    // Command stimulus
    if (send_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      cmd_valid = 1'b1;
      cmd_write = send_q[0].write;
      cmd_addr  = send_q[0].addr;
      cmd_size  = send_q[0].size;
      cmd_wdata = send_q[0].wdata;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_size  = 3'($urandom);
      cmd_wdata = $urandom;
    end
    #1;

    prev_stall       = (HTRANS == 2'b10) && !HREADY && !HRESP;
    prev_errfirst_ap = (HTRANS == 2'b10) && HRESP && !HREADY;
    prev_addr        = HADDR;

    if (s_dp && HREADY) begin
      if (c_write[s_idx]) begin
        checks++;
        if (HWDATA !== c_wdata[s_idx]) begin
          errors++;
          $display("FAIL hwdata cmd %0d: got %h, required %h", s_idx, HWDATA, c_wdata[s_idx]);
        end
      end
      done_cyc[s_idx] = cyc;
      n_done++;
      s_dp = 1'b0;
    end

    if (HREADY && HTRANS == 2'b10) begin
      checks++;
      if (issue_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_nonseq: got NONSEQ at %h, required IDLE", HADDR);
      end else begin
        idx = issue_q.pop_front();
        if (HADDR !== c_addr[idx] || HWRITE !== c_write[idx] || HSIZE !== c_size[idx]) begin
          errors++;
          $display("FAIL ap_fields cmd %0d: got %h/%0b/%0d, required %h/%0b/%0d", idx, HADDR,
                   HWRITE, HSIZE, c_addr[idx], c_write[idx], c_size[idx]);
        end
        if (plan_q.size() > 0) begin
          p = plan_q.pop_front();
        end else begin
          p.waits = rand_slave ? (($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0) : 0;
          p.err   = rand_slave && ($urandom_range(0, 7) == 0);
          p.fixed = 1'b0;
        end
        if (!p.fixed) p.rdata = $urandom;
        s_dp = 1'b1;
        s_idx = idx;
        s_waits = p.waits;
        s_err = p.err;
        s_err_ph = 0;
        s_rdata = p.rdata;
        exp_known[idx] = 1'b1;
        exp_err[idx]   = p.err;
        exp_rdata[idx] = (!c_write[idx] && !p.err) ? p.rdata : 32'h0;
      end
    end

    if (cmd_valid && cmd_ready) begin
      c = send_q.pop_front();
      mis = (c.size > 3'd2) || ((c.addr % (32'd1 << c.size)) != 0);
      c_addr[n_acc]  = c.addr;
      c_wdata[n_acc] = c.wdata;
      c_size[n_acc]  = c.size;
      c_write[n_acc] = c.write;
      c_mis[n_acc]   = mis;
      acc_cyc[n_acc] = cyc;
      if (mis) begin
        exp_known[n_acc] = 1'b1;
        exp_err[n_acc]   = 1'b1;
        exp_rdata[n_acc] = 32'h0;
      end else begin
        issue_q.push_back(n_acc);
        n_aligned_acc++;
      end
      n_acc++;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((send_q.size() > 0 || n_rsp < n_acc) && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (send_q.size() > 0 || n_rsp < n_acc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses of %0d accepted, %0d unsent, required all",
               n_rsp, n_acc, send_q.size());
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    model_reset();
    @(negedge HCLK);
    checks++;
    if ({HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK} !== 10'b0 || HADDR !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got HTRANS=%b HWRITE=%b HSIZE=%b HBURST=%b HMASTLOCK=%b HADDR=%h, required 0",
               HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HADDR);
    end
    checks++;
    if (HWDATA !== 32'h0 || HPROT !== 4'b0011) begin
      errors++;
      $display("FAIL reset_data: got HWDATA=%h HPROT=%b, required 0 0011", HWDATA, HPROT);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h busy=%b, required 0",
               rsp_valid, rsp_error, rsp_rdata, busy);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", cmd_ready);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_single_write();
    int n0 = n_rsp;
    int nonseq = 0;
    push_cmd(1'b1, 32'h4000_0000, 3'd2, 32'hDEAD_BEEF);
    push_plan(0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (HTRANS == 2'b10) nonseq++;
    end
    checks++;
    if (nonseq != 1) begin
      errors++;
      $display("FAIL wr_nonseq_cycles: got %0d, required 1", nonseq);
    end
    checks++;
    if (n_rsp != n0 + 1 || got_err[n0] !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp: got %0d responses err=%b, required 1 err=0", n_rsp - n0, got_err[n0]);
    end
  endtask

  task automatic test_single_read();
    int n0 = n_rsp;
    bit seen = 1'b0;
    bit moved = 1'b0;
    push_cmd(1'b0, 32'h0000_0100, 3'd2, 32'h0);
    push_plan(2, 1'b0, 1'b1, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      step();
      if (HTRANS == 2'b10) seen = 1'b1;
      if (seen && n_rsp == n0 && HADDR !== 32'h0000_0100) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL rd_haddr_stable: got HADDR change, required 00000100 held");
    end
    checks++;
    if (n_rsp != n0 + 1 || got_rdata[n0] !== 32'h1234_5678 || got_err[n0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp: got n=%0d rdata=%h err=%b, required 1 12345678 0",
               n_rsp - n0, got_rdata[n0], got_err[n0]);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = n_rsp;
    logic [1:0] tr [0:11];
    int f = -1;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'(i * 4), 3'd2, $urandom);
    for (int i = 0; i < 12; i++) begin
      step();
      tr[i] = HTRANS;
      if (f < 0 && HTRANS == 2'b10) f = i;
    end
    checks++;
    if (f < 0 || f > 6 || tr[f] != 2'b10 || tr[f + 1] != 2'b10 || tr[f + 2] != 2'b10 ||
        tr[f + 3] != 2'b10 || tr[f + 4] != 2'b00) begin
      errors++;
      $display("FAIL b2b_htrans: got first NONSEQ at %0d, required 4 NONSEQ then IDLE", f);
    end
    checks++;
    if (n_rsp != n0 + 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses, required 4", n_rsp - n0);
    end else begin
      for (int i = n0; i < n0 + 4; i++) begin
        checks++;
        if (rsp_cyc[i] - acc_cyc[i] != 3) begin
          errors++;
          $display("FAIL b2b_latency cmd %0d: got %0d cycles, required 3", i,
                   rsp_cyc[i] - acc_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_error();
    int n0 = n_rsp;
    int reissue = 0;
    bit bad_idle = 1'b0;
    logic [31:0] rd = $urandom;
    push_cmd(1'b1, 32'h10, 3'd2, $urandom);
    push_cmd(1'b0, 32'h14, 3'd2, 32'h0);
    push_plan(0, 1'b1, 1'b0, 32'h0);
    push_plan(0, 1'b0, 1'b1, rd);
    for (int i = 0; i < 12; i++) begin
      step();
      if (HRESP && HREADY && HTRANS !== 2'b00) bad_idle = 1'b1;
      if (HTRANS == 2'b10 && HADDR == 32'h14) reissue++;
    end
    checks++;
    if (bad_idle) begin
      errors++;
      $display("FAIL err_idle: got NONSEQ during error, required IDLE");
    end
    checks++;
    if (reissue < 2) begin
      errors++;
      $display("FAIL err_reissue: got %0d NONSEQ cycles for 0x14, required >=2", reissue);
    end
    checks++;
    if (n_rsp != n0 + 2 || got_err[n0] !== 1'b1 || got_err[n0 + 1] !== 1'b0 ||
        got_rdata[n0 + 1] !== rd) begin
      errors++;
      $display("FAIL err_rsp: got n=%0d err=%b,%b rdata=%h, required 2 1,0 %h",
               n_rsp - n0, got_err[n0], got_err[n0 + 1], got_rdata[n0 + 1], rd);
    end
  endtask

  task automatic test_misaligned();
    int n0 = n_rsp;
    int nonseq = 0;
    push_cmd(1'b1, 32'h2, 3'd2, $urandom);
    for (int i = 0; i < 6; i++) begin
      step();
      if (HTRANS == 2'b10) nonseq++;
    end
    checks++;
    if (nonseq != 0 || n_rsp != n0 + 1 || got_err[n0] !== 1'b1 || got_rdata[n0] !== 32'h0) begin
      errors++;
      $display("FAIL mis_word: got nonseq=%0d n=%0d err=%b, required 0 1 1",
               nonseq, n_rsp - n0, got_err[n0]);
    end
    n0 = n_rsp;
    push_cmd(1'b1, 32'h2, 3'd1, $urandom);
    drain(20);
    checks++;
    if (got_err[n0] !== 1'b0) begin
      errors++;
      $display("FAIL mis_half_ok: got err=%b, required 0", got_err[n0]);
    end
    // Rejected command queued behind a slow read must answer after it.
    n0 = n_rsp;
    push_cmd(1'b0, 32'h20, 3'd2, 32'h0);
    push_plan(3, 1'b0, 1'b0, 32'h0);
    push_cmd(1'b0, 32'h3, 3'd1, 32'h0);
    drain(30);
    checks++;
    if (rsp_cyc[n0 + 1] <= rsp_cyc[n0] || got_err[n0 + 1] !== 1'b1) begin
      errors++;
      $display("FAIL mis_order: got cycles %0d,%0d err=%b, required later and err=1",
               rsp_cyc[n0], rsp_cyc[n0 + 1], got_err[n0 + 1]);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    push_cmd(1'b0, 32'h30, 3'd2, 32'h0);
    push_plan(20, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    HRESETn = 1'b0;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got HTRANS=%b busy=%b rsp_valid=%b, required 00 0 0",
               HTRANS, busy, rsp_valid);
    end
    model_reset();
    cmd_valid = 1'b0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_no_rsp: got %0d responses, required 0", extra);
    end
  endtask

  task automatic test_random();
    int n0 = n_acc;
    rand_slave = 1'b1;
    gap_pct = 30;
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      push_cmd(1'($urandom), a, sz, $urandom);
    end
    drain(3000);
    checks++;
    if (n_acc - n0 != 150 || n_rsp != n_acc) begin
      errors++;
      $display("FAIL rand_count: got %0d accepted %0d responses, required 150 each",
               n_acc - n0, n_rsp - n0);
    end
    rand_slave = 1'b0;
    gap_pct = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_error();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
